input_skewer: RTL

- Feeder on the input side of the systolic array; the write-side counterpart of the output accumulator that de-skews results.
- Captures a full ARRAY_SIZE x ARRAY_SIZE operand matrix in one cycle, then streams it into the array edge as diagonally skewed lane vectors over 2*ARRAY_SIZE-1 steps.
- Each step carries an index and a valid/ready handshake, so the downstream array or buffer can stall the stream.

---
 rtl/input_skewer.sv | 126 ++++++++++++
 1 files changed

// File: rtl/input_skewer.sv
// input_skewer: feeds the input edge of the systolic array.
// Captures a full ARRAY_SIZE x ARRAY_SIZE operand matrix on an accepted start,
// then streams it as diagonally skewed lane vectors over 2*ARRAY_SIZE-1 steps
// under a valid/ready handshake.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   start      load mat_in and begin streaming (ignored while streaming)
//   mat_in     matrix, element (r,c) at [(c + ARRAY_SIZE*r)*DATA_WIDTH +: DATA_WIDTH]
//   out_ready  downstream accepts the current step
//   out_valid  skew_out/out_index hold a valid step
//   out_index  step number t, 0..2*ARRAY_SIZE-2
//   skew_out   lane r at [r*DATA_WIDTH +: DATA_WIDTH] = M[r][t-r] (0 outside)
//   busy       high in FEED and DONE
//   done       one-cycle pulse after the last step transfers
module input_skewer #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned ARRAY_SIZE  = 8,
  parameter int unsigned INDEX_WIDTH = 8
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic                                         start,
  input  logic [ARRAY_SIZE*ARRAY_SIZE*DATA_WIDTH-1:0]  mat_in,
  input  logic                                         out_ready,
  output logic                                         out_valid,
  output logic [INDEX_WIDTH-1:0]                       out_index,
  output logic [ARRAY_SIZE*DATA_WIDTH-1:0]             skew_out,
  output logic                                         busy,
  output logic                                         done
);

  localparam int unsigned MAT_W  = ARRAY_SIZE*ARRAY_SIZE*DATA_WIDTH;
  localparam int unsigned LANE_W = ARRAY_SIZE*DATA_WIDTH;
  localparam logic [INDEX_WIDTH-1:0] LAST_STEP = INDEX_WIDTH'(2*ARRAY_SIZE-2);

  typedef enum logic [1:0] {IDLE, FEED, DONE} state_e;

  state_e                  state_q, state_d;
  logic [MAT_W-1:0]        mat_q, mat_d;
  logic [INDEX_WIDTH-1:0]  t_q, t_d;
  logic                    valid_q, valid_d;
  logic [LANE_W-1:0]       skew_q, skew_d;

  // Lane r of step t carries M[r][t-r] when that column exists, else zero.
  function automatic logic [LANE_W-1:0] skew_step(input logic [MAT_W-1:0] mat,
                                                   input logic [INDEX_WIDTH-1:0] t);
    logic [LANE_W-1:0] v;
    int unsigned       tt;
    v  = '0;
    tt = 32'(t);
    for (int unsigned r = 0; r < ARRAY_SIZE; r++) begin
      if (tt >= r && (tt - r) < ARRAY_SIZE)
        v[r*DATA_WIDTH +: DATA_WIDTH] = mat[((tt - r) + ARRAY_SIZE*r)*DATA_WIDTH +: DATA_WIDTH];
    end
    return v;
  endfunction

  always_comb begin
    state_d = state_q;
    mat_d   = mat_q;
    t_d     = t_q;
    valid_d = valid_q;
    skew_d  = skew_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FEED;
          mat_d   = mat_in;
          t_d     = '0;
          valid_d = 1'b1;
          skew_d  = skew_step(mat_in, '0);
        end
      end
      FEED: begin
        if (valid_q && out_ready) begin
          if (t_q == LAST_STEP) begin
            state_d = DONE;
            valid_d = 1'b0;
            skew_d  = '0;
          end else begin
            t_d    = t_q + INDEX_WIDTH'(1);
            skew_d = skew_step(mat_q, t_q + INDEX_WIDTH'(1));
          end
        end
      end
      DONE: begin
        // The edge leaving DONE may already accept the next start, giving
        // back-to-back streams separated by exactly one done cycle.
        state_d = IDLE;
        if (start) begin
          state_d = FEED;
          mat_d   = mat_in;
          t_d     = '0;
          valid_d = 1'b1;
          skew_d  = skew_step(mat_in, '0);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      mat_q   <= '0;
      t_q     <= '0;
      valid_q <= 1'b0;
      skew_q  <= '0;
    end else begin
      state_q <= state_d;
      mat_q   <= mat_d;
      t_q     <= t_d;
      valid_q <= valid_d;
      skew_q  <= skew_d;
    end
  end

  assign out_valid = valid_q;
  assign out_index = t_q;
  assign skew_out  = skew_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);

endmodule
